if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch stage that drives the synchronous-read instruction memory (1-cycle BRAM latency).
//  Holds the PC and presents the next fetch address combinationally so memory data aligns with the PC register.
//  Applies stall, branch and jump redirects, and halt. Delivers {instruction, PC, valid} to the IF/ID register.
// PARAMETERS
//  ISIZE     18       instruction width (16 data + 2 parity bits from memory)
//  DSIZE     16       PC / address width
//  RESET_PC  16'h0000 PC value loaded on reset
// PORTS
//  Clk_In            in   1      system clock, rising edge
//  Rst_In            in   1      asynchronous, active-high reset
//  Stall_In          in   1      hold PC and instruction (hazard stall)
//  Branch_Taken_In   in   1      branch resolved taken (EX stage)
//  Branch_Target_In  in   DSIZE  branch target address
//  Jump_In           in   1      jump request (ID stage)
//  Jump_Target_In    in   DSIZE  jump target address
//  Halt_In           in   1      halt instruction decoded
//  Imem_Add_Out      out  DSIZE  fetch address to instruction memory (combinational)
//  Imem_Data_In      in   ISIZE  instruction from memory, registered by the memory
//  Instr_Out         out  ISIZE  instruction to IF/ID (= Imem_Data_In)
//  PC_Out            out  DSIZE  address of Instr_Out
//  PC_Plus1_Out      out  DSIZE  PC_Out + 1, mod 2^DSIZE
//  Valid_Out         out  1      Instr_Out is a correct-path instruction
//  Fetch_Count_Out   out  DSIZE  number of instructions delivered
// BEHAVIOUR
//  Reset (async, any time, including mid-fetch): pc_reg=RESET_PC, state=PRIME, Fetch_Count_Out=0.
//   Valid_Out=0 and Imem_Add_Out=RESET_PC while reset is held.
//  States:
//   PRIME: Imem_Add_Out=pc_reg, pc_reg holds, Valid_Out=0. Next state is RUN unconditionally.
//   RUN:   Imem_Add_Out=next_pc, pc_reg<=next_pc. Invariant: Imem_Data_In == mem[pc_reg].
//   HALT:  Imem_Add_Out=pc_reg, pc_reg holds, Valid_Out=0. Exits only on reset.
//  next_pc priority in RUN, highest first:
//   Branch_Taken_In -> Branch_Target_In
//   Jump_In         -> Jump_Target_In
//   Stall_In        -> pc_reg
//   otherwise       -> pc_reg+1, wrapping 16'hFFFF -> 16'h0000
//  redirect = Branch_Taken_In | Jump_In (RUN only). Redirect overrides stall and halt.
//  Valid_Out = (state==RUN) & ~redirect. It stays 1 during a stall, with Instr_Out/PC_Out held stable.
//  After a redirect, the instruction at the target appears with Valid_Out=1 exactly 1 cycle later.
//  Halt_In in RUN with no redirect: state<=HALT, pc_reg holds (halt address visible on PC_Out).
//  Fetch_Count_Out increments on each edge where Valid_Out & ~Stall_In; saturates at 16'hFFFF.
//  Inputs are ignored in PRIME and HALT. Memory uses Imem_Add_Out[9:0]; upper bits pass through unchanged.
//  Instr_Out, PC_Out and PC_Plus1_Out have no latency beyond the memory's own cycle; no extra register is added.
// TESTING
//  1. Reset release, memory preloaded mem[0..3]=A..D -> cycle0 Valid=0 (PRIME); cycles 1-4 Instr=A,B,C,D with PC=0,1,2,3; count=4.
//  2. Stall_In=1 for 3 cycles at PC=2 -> Instr/PC held at mem[2]/2, Valid=1, Imem_Add_Out=2, count frozen; resumes at PC=3.
//  3. Branch_Taken_In=1, target=16'h0010, asserted at PC=5 with Stall_In=1 -> Valid=0 that cycle; next cycle PC=0x10, Instr=mem[0x10], Valid=1.
//  4. Branch_Taken_In and Jump_In together (branch target 0x20, jump target 0x30) -> next PC=0x20.
//     Jump alone (target 0x30) -> next PC=0x30.
//  5. Halt_In at PC=7 -> HALT state: Valid=0, PC_Out=7 indefinitely. Halt_In together with a branch -> branch taken, no halt.
//  6. PC=16'hFFFF -> next PC=16'h0000, PC_Plus1_Out at 0xFFFF is 0x0000.
//     Rst_In pulsed mid-run between edges -> outputs reset immediately, PRIME follows.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and drives a 1-cycle synchronous-read instruction memory.
// It handles branch/jump redirects, stalls and halt, and delivers {instr, pc, valid} to IF/ID.
module if_fetch_unit #(
  parameter int unsigned         ISIZE    = 18,
  parameter int unsigned         DSIZE    = 16,
  parameter logic [DSIZE-1:0]    RESET_PC = '0
) (
  input  logic             Clk_In,
  input  logic             Rst_In,
  input  logic             Stall_In,
  input  logic             Branch_Taken_In,
  input  logic [DSIZE-1:0] Branch_Target_In,
  input  logic             Jump_In,
  input  logic [DSIZE-1:0] Jump_Target_In,
  input  logic             Halt_In,
  output logic [DSIZE-1:0] Imem_Add_Out,
  input  logic [ISIZE-1:0] Imem_Data_In,
  output logic [ISIZE-1:0] Instr_Out,
  output logic [DSIZE-1:0] PC_Out,
  output logic [DSIZE-1:0] PC_Plus1_Out,
  output logic             Valid_Out,
  output logic [DSIZE-1:0] Fetch_Count_Out
);

  typedef enum logic [1:0] {StPrime, StRun, StHalt} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [DSIZE-1:0] r_pc;
  logic [DSIZE-1:0] w_next_pc;
  logic [DSIZE-1:0] r_count;
  logic             w_redirect;
  logic             w_valid;
  logic             w_count_inc;

  always_comb begin
    w_redirect   = (r_state == StRun) & (Branch_Taken_In | Jump_In);
    w_valid      = (r_state == StRun) & ~w_redirect;
    w_next_pc    = r_pc;
    w_state_next = r_state;
    unique case (r_state)
      StPrime: w_state_next = StRun;
      StRun: begin
        if (Branch_Taken_In) begin
          w_next_pc = Branch_Target_In;
        end else if (Jump_In) begin
          w_next_pc = Jump_Target_In;
        end else if (Stall_In || Halt_In) begin
          w_next_pc = r_pc;
        end else begin
          w_next_pc = r_pc + 1'b1;
        end
        if (Halt_In && !w_redirect) begin
          w_state_next = StHalt;
        end
      end
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StPrime;
    endcase
    w_count_inc = w_valid & ~Stall_In & (r_count != {DSIZE{1'b1}});
  end

  // The memory is addressed with the PC we are about to hold, so its registered data matches r_pc.
  assign Imem_Add_Out    = w_next_pc;
  assign Instr_Out       = Imem_Data_In;
  assign PC_Out          = r_pc;
  assign PC_Plus1_Out    = r_pc + 1'b1;
  assign Valid_Out       = w_valid;
  assign Fetch_Count_Out = r_count;

  always_ff @(posedge Clk_In or posedge Rst_In) begin
    if (Rst_In) begin
      r_state <= StPrime;
      r_pc    <= RESET_PC;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_next_pc;
      if (w_count_inc) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random traffic, checked against a
// cycle-level reference model of the fetch rules and a behavioural 1-cycle BRAM.
module tb_if_fetch_unit;

  localparam int unsigned ISIZE = 18;
  localparam int unsigned DSIZE = 16;

  logic             clk;
  logic             rst;
  logic             stall;
  logic             br;
  logic [DSIZE-1:0] br_tgt;
  logic             jmp;
  logic [DSIZE-1:0] jmp_tgt;
  logic             halt;
  logic [DSIZE-1:0] imem_addr;
  logic [ISIZE-1:0] imem_data;
  logic [ISIZE-1:0] instr;
  logic [DSIZE-1:0] pc;
  logic [DSIZE-1:0] pc_p1;
  logic             valid;
  logic [DSIZE-1:0] fcount;

  int checks   = 0;
  int failures = 0;

  logic [ISIZE-1:0] mem [0:1023];

  // Model state: phase 0 = priming, 1 = running, 2 = halted.
  int               m_phase;
  logic [DSIZE-1:0] m_pc;
  int               m_count;

  if_fetch_unit #(
    .ISIZE    (ISIZE),
    .DSIZE    (DSIZE),
    .RESET_PC (16'h0000)
  ) dut (
    .Clk_In           (clk),
    .Rst_In           (rst),
    .Stall_In         (stall),
    .Branch_Taken_In  (br),
    .Branch_Target_In (br_tgt),
    .Jump_In          (jmp),
    .Jump_Target_In   (jmp_tgt),
    .Halt_In          (halt),
    .Imem_Add_Out     (imem_addr),
    .Imem_Data_In     (imem_data),
    .Instr_Out        (instr),
    .PC_Out           (pc),
    .PC_Plus1_Out     (pc_p1),
    .Valid_Out        (valid),
    .Fetch_Count_Out  (fcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    imem_data <= mem[imem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: entered just after a negedge, returns at the next negedge.
  task automatic step(input logic b, input logic [DSIZE-1:0] bt, input logic j,
                      input logic [DSIZE-1:0] jt, input logic s, input logic h);
    logic             exp_valid;
    logic [DSIZE-1:0] exp_addr;
    br = b; br_tgt = bt; jmp = j; jmp_tgt = jt; stall = s; halt = h;
    #1;
    exp_valid = (m_phase == 1) && !(b || j);
    if (m_phase != 1)  exp_addr = m_pc;
    else if (b)        exp_addr = bt;
    else if (j)        exp_addr = jt;
    else if (s || h)   exp_addr = m_pc;
    else               exp_addr = m_pc + 16'd1;
    chk("valid", {31'd0, valid}, {31'd0, exp_valid});
    chk("pc", {16'd0, pc}, {16'd0, m_pc});
    chk("pc_plus1", {16'd0, pc_p1}, {16'd0, m_pc + 16'd1});
    chk("imem_addr", {16'd0, imem_addr}, {16'd0, exp_addr});
    chk("fetch_count", {16'd0, fcount}, m_count);
    if (m_phase != 0) chk("instr", {14'd0, instr}, {14'd0, mem[m_pc[9:0]]});
    @(posedge clk);
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (exp_valid && !s && m_count < 65535) m_count++;
      m_pc = exp_addr;
      if (h && !(b || j)) m_phase = 2;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0);
  endtask

  // Reset pulse between edges; outputs must react without waiting for a clock.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_addr", {16'd0, imem_addr}, 32'd0);
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_count", {16'd0, fcount}, 32'd0);
    #1;
    rst = 1'b0;
    m_phase = 0;
    m_pc    = 16'h0000;
    m_count = 0;
  endtask

  initial begin
    logic [DSIZE-1:0] t;
    for (int i = 0; i < 1024; i++) mem[i] = ISIZE'($urandom);
    rst = 1'b1; stall = 1'b0; br = 1'b0; jmp = 1'b0; halt = 1'b0;
    br_tgt = '0; jmp_tgt = '0;
    m_phase = 0; m_pc = '0; m_count = 0;
    repeat (2) @(negedge clk);
    pulse_reset();

    // Prime, then deliver PC 0 and 1; stall three cycles at PC 2.
    idle(3);
    repeat (3) step(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(3);
    // At PC 5: branch to 0x10 while stalled.
    step(1'b1, 16'h0010, 1'b0, 16'h0, 1'b1, 1'b0);
    idle(1);
    // Branch beats jump, then jump alone.
    step(1'b1, 16'h0020, 1'b1, 16'h0030, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 16'h0030, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 16'h0000, 1'b1, 16'h0007, 1'b0, 1'b0);
    // Halt with branch at PC 7: branch wins.
    t = 16'($urandom_range(8, 1000));
    step(1'b1, t, 1'b0, 16'h0, 1'b0, 1'b1);
    chk("halt_branch_pc", {16'd0, pc}, {16'd0, t});
    step(1'b0, 16'h0, 1'b1, 16'h0007, 1'b0, 1'b0);
    step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'($urandom), 16'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end
    chk("halted_pc", {16'd0, pc}, 32'd7);
    chk("halted_valid", {31'd0, valid}, 32'd0);

    // Wrap at 0xFFFF.
    pulse_reset();
    idle(2);
    step(1'b0, 16'h0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    chk("wrap_plus1", {16'd0, pc_p1}, 32'd0);
    idle(2);
    chk("wrap_pc", {16'd0, pc}, 32'd1);

    // Random traffic, including mid-run resets.
    for (int i = 0; i < 400; i++) begin
      if (m_phase == 2 && $urandom_range(0, 3) == 0) pulse_reset();
      else if ($urandom_range(0, 60) == 0) pulse_reset();
      step($urandom_range(0, 7) == 0, 16'($urandom), $urandom_range(0, 7) == 0, 16'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
